fifo_shadow_checker: RTL
========================

// Module: fifo_shadow_checker
// PURPOSE
//  Synthesizable, multi-channel shadow checker for fifo_v3-style FIFOs.
//  Sits beside NUM_CH FIFO instances in simulation, emulation or FPGA builds.
//  Per channel it keeps its own occupancy model and compares it with the
//  FIFO status outputs every cycle; on a mismatch it raises a sticky error.
//  Covers both normal and fall-through modes.
// PARAMETERS
//  NUM_CH        1   number of independent FIFO channels checked
//  DEPTH         8   FIFO depth per channel, >=1 (elaboration $error if 0)
//  DATA_WIDTH    32  FIFO data width (used by data scoreboard only)
//  FALL_THROUGH  0   1: pop on an empty FIFO with a same-cycle push is legal
//  ADDR_DEPTH    derived, DEPTH>1 ? $clog2(DEPTH) : 1; do not override
// PORTS
//  clk_i       in   1                      clock
//  rst_ni      in   1                      async reset, active low
//  clr_err_i   in   1                      clear all sticky errors
//  flush_i     in   NUM_CH                 FIFO flush, per channel
//  push_i      in   NUM_CH                 FIFO push request
//  pop_i       in   NUM_CH                 FIFO pop request
//  full_i      in   NUM_CH                 FIFO full_o
//  empty_i     in   NUM_CH                 FIFO empty_o
//  usage_i     in   NUM_CH*ADDR_DEPTH      FIFO usage_o, channel c at [c*ADDR_DEPTH +: ADDR_DEPTH]
//  wdata_i     in   NUM_CH*DATA_WIDTH      FIFO data_i
//  rdata_i     in   NUM_CH*DATA_WIDTH      FIFO data_o
//  cnt_o       out  NUM_CH*(ADDR_DEPTH+1)  shadow occupancy per channel
//  err_o       out  NUM_CH                 sticky error per channel
//  err_code_o  out  NUM_CH*5               sticky cause bits per channel
// BEHAVIOUR
//  - Reset (rst_ni low, async): cnt_o=0, err_o=0, err_code_o=0, scoreboard pointers=0.
//  - Accepted push pa = push_i & ~full_i.
//  - Accepted pop  pp = pop_i & ~empty_i.
//  - FALL_THROUGH=1 also accepts pp when empty_i & push_i & pop_i (pass-through).
//  - Count update, priority order:
//    - flush_i: cnt<=0, scoreboard cleared; no checks of pa/pp that cycle.
//    - pa&pp: cnt unchanged.
//    - pa only: cnt+1.
//    - pp only: cnt-1.
//  - Boundaries:
//    - push when full with pop: only the pop is accepted, cnt-1.
//    - pop when empty with no push: ignored.
//    - cnt arithmetic is ADDR_DEPTH+1 bits and must never exceed DEPTH or go below 0.
//      If the model would, set code[1] instead of wrapping.
//  - Combinational checks vs registered cnt, evaluated each cycle while rst_ni high:
//    - code[0]: empty_i != (cnt==0)
//    - code[1]: full_i != (cnt==DEPTH), or shadow over/underflow
//    - code[2]: usage_i != cnt[ADDR_DEPTH-1:0] (usage wraps to 0 at full when DEPTH=2^ADDR_DEPTH)
//    - code[3]: data mismatch (see CONFIGURATION)
//    - code[4]: protocol warning: push_i&full_i&~pop_i, or pop_i&empty_i&~(FALL_THROUGH&push_i)
//  - Error latency: cause bits are ORed into err_code_o on the next clk edge.
//    err_o = |err_code_o, so err_o asserts 1 cycle after the offending cycle.
//  - clr_err_i clears err_code_o; a cause present in the same cycle wins (set beats clear).
//  - Channels are fully independent; no cross-channel state.
// CONFIGURATION
//  - Macro FIFO_SHADOW_CHECK_DATA_EN defined:
//    - Per channel DEPTH x DATA_WIDTH shadow queue with read/write pointers wrapping at DEPTH-1.
//    - Written with wdata_i on pa.
//    - On pp, rdata_i is compared with the queue head; in the fall-through case it is
//      compared with wdata_i instead. Mismatch sets code[3].
//    - flush_i resets both pointers.
//  - Macro undefined: no storage, code[3] tied 0; wdata_i/rdata_i unused.
// TESTING (DEPTH=4, NUM_CH=2, FALL_THROUGH=0 unless stated)
//  - 4 pushes on ch0, 0 pops -> cnt_o[ch0]=4; with correct DUT full_i=1 and usage_i=0,
//    err_o=0; ch1 cnt stays 0.
//  - Force DUT full_i=0 at cnt=4 -> err_code_o[ch0]=5'b00010 and err_o[0]=1 next cycle;
//    clr_err_i for 1 cycle with fault removed -> err_code_o=0.
//  - Push+pop on a full FIFO -> cnt 4->3, no error.
//    Pop on empty -> cnt stays 0, code[4] set.
//  - flush_i at cnt=3 with a same-cycle push -> cnt=0, no error; next push -> cnt=1.
//  - FALL_THROUGH=1, empty, push+pop with wdata_i=rdata_i=32'hA5A5_0001 -> cnt stays 0, no error.
//    With DATA_EN and rdata_i=32'h0 instead -> code[3] set.
//  - DATA_EN: push 32'h1,32'h2, corrupt rdata_i to 32'h3 on the 2nd pop -> code[3] set only on ch0.
//    Assert rst_ni low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/fifo_shadow_checker.sv
// fifo_shadow_checker: per-channel occupancy shadow for fifo_v3-style FIFOs.
// Each channel rebuilds the expected count from push/pop/flush and compares
// it every cycle with the FIFO's empty/full/usage outputs. Disagreements are
// latched as sticky cause bits.
// Optional feature: define FIFO_SHADOW_CHECK_DATA_EN to add a per-channel data
// scoreboard that checks the FIFO read data against the written data.
//
// Transfer semantics: a push is accepted when push_i is high and full_i is low.
// A pop is accepted when pop_i is high and empty_i is low. In fall-through
// builds a pop on an empty FIFO is also accepted when a push arrives in the
// same cycle, and the data passes straight through.
module fifo_shadow_checker #(
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clr_err_i,
  input  logic [NUM_CH-1:0]                flush_i,
  input  logic [NUM_CH-1:0]                push_i,
  input  logic [NUM_CH-1:0]                pop_i,
  input  logic [NUM_CH-1:0]                full_i,
  input  logic [NUM_CH-1:0]                empty_i,
  input  logic [NUM_CH*ADDR_DEPTH-1:0]     usage_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     rdata_i,
  output logic [NUM_CH*(ADDR_DEPTH+1)-1:0] cnt_o,
  output logic [NUM_CH-1:0]                err_o,
  output logic [NUM_CH*5-1:0]              err_code_o
);

  localparam int unsigned CW = ADDR_DEPTH + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEPTH == 0) begin : g_depth_err
    $error("fifo_shadow_checker: DEPTH must be at least 1");
  end

`ifndef FIFO_SHADOW_CHECK_DATA_EN
  // Data buses only matter when the scoreboard is built in.
  logic unused_data;
  assign unused_data = ^{wdata_i, rdata_i};
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic                  push, pop, full, empty, flush;
    logic [ADDR_DEPTH-1:0] usage;
    logic                  ft, pa, pp;
    logic                  ovf, unf, data_err;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4:0]            code_q, cause;

    assign push  = push_i[c];
    assign pop   = pop_i[c];
    assign full  = full_i[c];
    assign empty = empty_i[c];
    assign flush = flush_i[c];
    assign usage = usage_i[c*ADDR_DEPTH +: ADDR_DEPTH];

    // Pass-through: empty FIFO, same-cycle push and pop, fall-through build.
    assign ft = FALL_THROUGH & empty & push & pop;
    assign pa = push & ~full;
    assign pp = (pop & ~empty) | ft;

    // Next shadow count; an impossible step is flagged and the count held.
    always_comb begin
      cnt_d = cnt_q;
      ovf   = 1'b0;
      unf   = 1'b0;
      if (flush) begin
        cnt_d = '0;
      end else if (pa && !pp) begin
        if (cnt_q == CNT_FULL) ovf = 1'b1;
        else                   cnt_d = cnt_q + CNT_ONE;
      end else if (pp && !pa) begin
        if (cnt_q == '0) unf = 1'b1;
        else             cnt_d = cnt_q - CNT_ONE;
      end
    end

    assign cause[0] = empty != (cnt_q == '0);
    assign cause[1] = (full != (cnt_q == CNT_FULL)) | ovf | unf;
    assign cause[2] = usage != cnt_q[ADDR_DEPTH-1:0];
    assign cause[3] = data_err;
    assign cause[4] = (push & full & ~pop) | (pop & empty & ~(FALL_THROUGH & push));

    // Shadow count and sticky causes; a new cause wins over a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q  <= '0;
        code_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        code_q <= clr_err_i ? cause : (code_q | cause);
      end
    end

    assign cnt_o[c*CW +: CW]   = cnt_q;
    assign err_code_o[c*5 +: 5] = code_q;
    assign err_o[c]             = |code_q;

`ifdef FIFO_SHADOW_CHECK_DATA_EN
    localparam logic [ADDR_DEPTH-1:0] PTR_LAST = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH-1:0] PTR_ONE  = ADDR_DEPTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] wptr_q, rptr_q;
    logic [DATA_WIDTH-1:0] wdata, rdata;
    logic                  wr_en, rd_en;

    assign wdata = wdata_i[c*DATA_WIDTH +: DATA_WIDTH];
    assign rdata = rdata_i[c*DATA_WIDTH +: DATA_WIDTH];
    // Pass-through data never enters the queue; over/underflow steps are not stored.
    assign wr_en = pa & ~ft & ~ovf & ~flush;
    assign rd_en = pp & ~ft & ~unf & ~flush;
    assign data_err = ~flush & ((ft & (rdata != wdata)) |
                                (rd_en & (rdata != mem_q[rptr_q])));

    // Queue pointers wrap at DEPTH-1 and restart on flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (wr_en) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_ONE;
        if (rd_en) rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_ONE;
      end
    end

    // Queue storage needs no reset; only entries behind the pointers are read.
    always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wptr_q] <= wdata;
    end
`else
    assign data_err = 1'b0;
`endif
  end

endmodule
